axi_cmd_scheduler: RTL and testbench

- AXI-side front end of the AXI-to-AHB bridge.
- Arbitrates between AXI write bursts (AW+W) and read bursts (AR) and splits each burst into single-beat commands.
- Pushes each beat into the command FIFOs (addr, data, state, id_send, size) that the AHB master controller drains as SINGLE transfers.
- Round-robin between write and read at burst granularity.

---
 rtl/axi_cmd_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_axi_cmd_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_scheduler.sv
// axi_cmd_scheduler: AXI-side front end of the AXI-to-AHB bridge.
// Grants AW+W write bursts and AR read bursts round-robin at burst granularity
// and splits every burst into single-beat pushes into the addr/data/state/
// id_send/size command FIFOs drained by the AHB master controller.
// Optional macro BURST_4K_CHECK_EN: flags INCR bursts that cross a 4 KB page
// at capture and keeps INCR address increments inside the current 4 KB page.
module axi_cmd_scheduler #(
    parameter int unsigned ID_W  = 9,
    parameter int unsigned LEN_W = 4
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic             awvalid,
    output logic             awready,
    input  logic [31:0]      awaddr,
    input  logic [ID_W-1:0]  awid,
    input  logic [LEN_W-1:0] awlen,
    input  logic [2:0]       awsize,
    input  logic [1:0]       awburst,
    input  logic             wvalid,
    output logic             wready,
    input  logic [63:0]      wdata,
    input  logic             wlast,
    input  logic             arvalid,
    output logic             arready,
    input  logic [31:0]      araddr,
    input  logic [ID_W-1:0]  arid,
    input  logic [LEN_W-1:0] arlen,
    input  logic [2:0]       arsize,
    input  logic [1:0]       arburst,
    output logic             addr_w_en,
    output logic [31:0]      cmd_addr,
    output logic             data_w_en,
    output logic [63:0]      cmd_data,
    output logic             state_w_en,
    output logic             cmd_write,
    output logic             id_send_w_en,
    output logic [ID_W-1:0]  cmd_id,
    output logic             size_w_en,
    output logic [2:0]       cmd_size,
    input  logic             addr_fifo_full,
    input  logic             data_fifo_full,
    input  logic             state_fifo_full,
    input  logic             id_send_fifo_full,
    input  logic             size_fifo_full,
    output logic             burst_err
);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;
    typedef enum logic [1:0] {BT_FIXED = 2'd0, BT_INCR = 2'd1, BT_WRAP = 2'd2, BT_RSVD = 2'd3} burst_t;

    state_t           state_q;
    logic             prio_w_q;
    logic             is_write_q;
    logic [31:0]      addr_q;
    logic [ID_W-1:0]  id_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic [2:0]       size_q;
    burst_t           burst_q;

    logic             grant_w, grant_r;
    logic [31:0]      sel_addr;
    logic [ID_W-1:0]  sel_id;
    logic [LEN_W-1:0] sel_len;
    logic [2:0]       sel_size, cap_size;
    logic [1:0]       sel_burst;
    burst_t           cap_burst;
    logic             cap_err;
    logic             cmd_ok, wr_push, rd_push, push, last_beat;
    logic [31:0]      inc, wrap_mask, addr_d;
`ifdef BURST_4K_CHECK_EN
    logic [31:0]      span, last_byte;
`endif

    assign cmd_ok    = ~(addr_fifo_full | state_fifo_full | id_send_fifo_full | size_fifo_full);
    // Reset gates every handshake and push so nothing leaks out while hreset is high.
    assign grant_w   = ~hreset & (state_q == IDLE) & awvalid & (~arvalid | prio_w_q);
    assign grant_r   = ~hreset & (state_q == IDLE) & arvalid & (~awvalid | ~prio_w_q);
    assign wready    = ~hreset & (state_q == WR_BURST) & cmd_ok & ~data_fifo_full;
    assign wr_push   = wready & wvalid;
    assign rd_push   = ~hreset & (state_q == RD_BURST) & cmd_ok;
    assign push      = wr_push | rd_push;
    assign last_beat = (beat_cnt_q == len_q);

    assign awready      = grant_w;
    assign arready      = grant_r;
    assign addr_w_en    = push;
    assign state_w_en   = push;
    assign id_send_w_en = push;
    assign size_w_en    = push;
    assign data_w_en    = wr_push;
    assign cmd_addr     = addr_q;
    assign cmd_data     = wr_push ? wdata : '0;
    assign cmd_write    = is_write_q;
    assign cmd_id       = id_q;
    assign cmd_size     = size_q;
    assign burst_err    = ((grant_w | grant_r) & cap_err) | (wr_push & (wlast ^ last_beat));

    // Select the granted channel and sanitise its size/burst fields for capture.
    always_comb begin
        sel_addr  = grant_w ? awaddr  : araddr;
        sel_id    = grant_w ? awid    : arid;
        sel_len   = grant_w ? awlen   : arlen;
        sel_size  = grant_w ? awsize  : arsize;
        sel_burst = grant_w ? awburst : arburst;
        cap_size  = (sel_size > 3'd3) ? 3'd3 : sel_size;
        cap_err   = (sel_size > 3'd3);
        case (sel_burst)
            2'd0: cap_burst = BT_FIXED;
            2'd1: cap_burst = BT_INCR;
            2'd2: begin
                // Legal wrap lengths are 2^n-1 beats-minus-one, i.e. len+1 a power of two above 1.
                if ((sel_len != '0) && ((sel_len & (sel_len + LEN_W'(1))) == '0)) begin
                    cap_burst = BT_WRAP;
                end else begin
                    cap_burst = BT_INCR;
                    cap_err   = 1'b1;
                end
            end
            default: begin
                cap_burst = BT_INCR;
                cap_err   = 1'b1;
            end
        endcase
`ifdef BURST_4K_CHECK_EN
        span      = (32'(sel_len) + 32'd1) << cap_size;
        last_byte = {20'd0, sel_addr[11:0]} + span - 32'd1;
        if ((cap_burst == BT_INCR) && (last_byte[31:12] != '0)) cap_err = 1'b1;
`endif
    end

    // Address of the beat following the current one.
    always_comb begin
        inc       = 32'd1 << size_q;
        wrap_mask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
        case (burst_q)
            BT_FIXED: addr_d = addr_q;
            BT_WRAP:  addr_d = (addr_q & ~wrap_mask) | ((addr_q + inc) & wrap_mask);
            default: begin
`ifdef BURST_4K_CHECK_EN
                addr_d = {addr_q[31:12], addr_q[11:0] + inc[11:0]};
`else
                addr_d = addr_q + inc;
`endif
            end
        endcase
    end

    // Burst FSM: capture on grant, step one beat per push, hand priority over at burst end.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= IDLE;
            prio_w_q   <= 1'b1;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= BT_FIXED;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_w | grant_r) begin
                        addr_q     <= sel_addr;
                        id_q       <= sel_id;
                        len_q      <= sel_len;
                        size_q     <= cap_size;
                        burst_q    <= cap_burst;
                        beat_cnt_q <= '0;
                        is_write_q <= grant_w;
                        state_q    <= grant_w ? WR_BURST : RD_BURST;
                    end
                end
                WR_BURST, RD_BURST: begin
                    if (push) begin
                        addr_q     <= addr_d;
                        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                        if (last_beat) begin
                            state_q  <= IDLE;
                            prio_w_q <= (state_q == RD_BURST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_cmd_scheduler.sv
// Scoreboard bench for axi_cmd_scheduler: stimulus tasks push expected grants
// and beats computed from closed-form burst rules; a negedge monitor pops them.
`timescale 1ns/1ps
module tb_axi_cmd_scheduler;
    localparam int unsigned ID_W  = 9;
    localparam int unsigned LEN_W = 4;

    logic             hclk = 1'b0;
    logic             hreset = 1'b1;
    logic             awvalid = 1'b0, awready;
    logic [31:0]      awaddr = '0;
    logic [ID_W-1:0]  awid = '0;
    logic [LEN_W-1:0] awlen = '0;
    logic [2:0]       awsize = '0;
    logic [1:0]       awburst = '0;
    logic             wvalid = 1'b0, wready;
    logic [63:0]      wdata = '0;
    logic             wlast = 1'b0;
    logic             arvalid = 1'b0, arready;
    logic [31:0]      araddr = '0;
    logic [ID_W-1:0]  arid = '0;
    logic [LEN_W-1:0] arlen = '0;
    logic [2:0]       arsize = '0;
    logic [1:0]       arburst = '0;
    logic             addr_w_en, data_w_en, state_w_en, id_send_w_en, size_w_en;
    logic [31:0]      cmd_addr;
    logic [63:0]      cmd_data;
    logic             cmd_write;
    logic [ID_W-1:0]  cmd_id;
    logic [2:0]       cmd_size;
    logic             addr_fifo_full = 1'b0, data_fifo_full = 1'b0, state_fifo_full = 1'b0;
    logic             id_send_fifo_full = 1'b0, size_fifo_full = 1'b0;
    logic             burst_err;

    always #5 hclk = ~hclk;

    axi_cmd_scheduler #(.ID_W(ID_W), .LEN_W(LEN_W)) dut (
        .hclk(hclk), .hreset(hreset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .addr_w_en(addr_w_en), .cmd_addr(cmd_addr), .data_w_en(data_w_en), .cmd_data(cmd_data),
        .state_w_en(state_w_en), .cmd_write(cmd_write), .id_send_w_en(id_send_w_en), .cmd_id(cmd_id),
        .size_w_en(size_w_en), .cmd_size(cmd_size),
        .addr_fifo_full(addr_fifo_full), .data_fifo_full(data_fifo_full),
        .state_fifo_full(state_fifo_full), .id_send_fifo_full(id_send_fifo_full),
        .size_fifo_full(size_fifo_full), .burst_err(burst_err)
    );

    typedef struct {
        logic [31:0]     addr;
        logic            wr;
        logic [63:0]     data;
        logic [ID_W-1:0] id;
        logic [2:0]      size;
        logic            err;
    } beat_t;
    typedef struct {
        logic wr;
        logic cap_err;
    } grant_t;

    beat_t       beat_q[$];
    grant_t      grant_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          prio_w_m = 1'b1;
    bit          rand_full_en = 1'b0;
    logic [4:0]  forced_full = '0;   // {addr, data, state, id_send, size}
    bit          gap_en = 1'b0;
    int unsigned wl_mode = 0;        // 0 correct wlast, 1 random flips, 2 also high on beat 0
    bit          data_fixed = 1'b0;
    logic [63:0] data_base = '0;
    logic [63:0] wdat_a [16];
    logic        wl_a [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=no handshake within bound required=handshake", name);
    endtask

    // Beat address from the burst rules in closed form.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int unsigned len,
                                               input int unsigned sz, input int unsigned bt,
                                               input int unsigned i);
        logic [31:0] bytes, span, base;
`ifdef BURST_4K_CHECK_EN
        logic [31:0] off;
`endif
        bytes = 32'd1 << sz;
        if (bt == 0) return a;
        if (bt == 2) begin
            span = (len + 1) * bytes;
            base = a - (a % span);
            return base + (((a - base) + i * bytes) % span);
        end
`ifdef BURST_4K_CHECK_EN
        off = {20'd0, a[11:0]} + i * bytes;
        return {a[31:12], off[11:0]};
`else
        return a + i * bytes;
`endif
    endfunction

    task automatic model_burst(input bit wr, input logic [31:0] a, input logic [ID_W-1:0] id,
                               input int unsigned len, input int unsigned size,
                               input int unsigned bt, input int unsigned n_push);
        int unsigned sz, bt_eff;
        bit          cerr;
        beat_t       b;
        grant_t      g;
        sz     = (size > 3) ? 3 : size;
        cerr   = (size > 3);
        bt_eff = bt;
        if (bt == 3) begin bt_eff = 1; cerr = 1'b1; end
        if (bt == 2 && !(len inside {1, 3, 7, 15})) begin bt_eff = 1; cerr = 1'b1; end
`ifdef BURST_4K_CHECK_EN
        if (bt_eff == 1 && ({20'd0, a[11:0]} + (len + 1) * (32'd1 << sz) - 32'd1) > 32'hFFF) cerr = 1'b1;
`endif
        g.wr = wr;
        g.cap_err = cerr;
        grant_q.push_back(g);
        for (int unsigned i = 0; i < n_push; i++) begin
            b.addr = model_addr(a, len, sz, bt_eff, i);
            b.wr   = wr;
            b.id   = id;
            b.size = 3'(sz);
            if (wr) begin
                wdat_a[i] = data_fixed ? data_base + 64'(i) : {$urandom, $urandom};
                case (wl_mode)
                    0:       wl_a[i] = (i == len);
                    1:       wl_a[i] = (i == len) ^ ($urandom_range(0, 7) == 0);
                    default: wl_a[i] = (i == 0) || (i == len);
                endcase
                b.data = wdat_a[i];
                b.err  = (wl_a[i] != (i == len));
            end else begin
                b.data = '0;
                b.err  = 1'b0;
            end
            beat_q.push_back(b);
        end
    endtask

    task automatic drive_aw(input logic [31:0] a, input logic [ID_W-1:0] id, input int unsigned len,
                            input int unsigned size, input int unsigned bt);
        int unsigned n;
        n = 0;
        awaddr = a; awid = id; awlen = LEN_W'(len); awsize = 3'(size); awburst = 2'(bt);
        awvalid = 1'b1;
        @(negedge hclk);
        while (!awready && n < 500) begin n++; @(negedge hclk); end
        if (!awready) timeout_fail("aw_handshake");
        @(posedge hclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [31:0] a, input logic [ID_W-1:0] id, input int unsigned len,
                            input int unsigned size, input int unsigned bt);
        int unsigned n;
        n = 0;
        araddr = a; arid = id; arlen = LEN_W'(len); arsize = 3'(size); arburst = 2'(bt);
        arvalid = 1'b1;
        @(negedge hclk);
        while (!arready && n < 500) begin n++; @(negedge hclk); end
        if (!arready) timeout_fail("ar_handshake");
        @(posedge hclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic drive_w(input int unsigned len);
        int unsigned n;
        for (int unsigned i = 0; i <= len; i++) begin
            n = 0;
            if (gap_en && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge hclk); #1;
            end
            wdata = wdat_a[i]; wlast = wl_a[i]; wvalid = 1'b1;
            @(negedge hclk);
            while (!wready && n < 500) begin n++; @(negedge hclk); end
            if (!wready) timeout_fail("w_handshake");
            @(posedge hclk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((beat_q.size() != 0 || grant_q.size() != 0) && n < 3000) begin
            @(posedge hclk);
            n++;
        end
        if (beat_q.size() != 0 || grant_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual pending beats=%0d grants=%0d required=0", beat_q.size(), grant_q.size());
            beat_q.delete();
            grant_q.delete();
        end
        repeat (2) @(posedge hclk);
        #1;
    endtask

    task automatic run_write(input logic [31:0] a, input logic [ID_W-1:0] id, input int unsigned len,
                             input int unsigned size, input int unsigned bt);
        model_burst(1'b1, a, id, len, size, bt, len + 1);
        drive_aw(a, id, len, size, bt);
        drive_w(len);
        prio_w_m = 1'b0;
        drain();
    endtask

    task automatic run_read(input logic [31:0] a, input logic [ID_W-1:0] id, input int unsigned len,
                            input int unsigned size, input int unsigned bt);
        model_burst(1'b0, a, id, len, size, bt, len + 1);
        drive_ar(a, id, len, size, bt);
        prio_w_m = 1'b1;
        drain();
    endtask

    // Both channels valid together: the side holding priority goes first, and the
    // side finishing second hands priority back, so the pointer ends unchanged.
    task automatic run_both(input logic [31:0] wa, input logic [ID_W-1:0] wid, input int unsigned wlen,
                            input int unsigned wsz, input int unsigned wbt,
                            input logic [31:0] ra, input logic [ID_W-1:0] rid, input int unsigned rlen,
                            input int unsigned rsz, input int unsigned rbt);
        if (prio_w_m) begin
            model_burst(1'b1, wa, wid, wlen, wsz, wbt, wlen + 1);
            model_burst(1'b0, ra, rid, rlen, rsz, rbt, rlen + 1);
        end else begin
            model_burst(1'b0, ra, rid, rlen, rsz, rbt, rlen + 1);
            model_burst(1'b1, wa, wid, wlen, wsz, wbt, wlen + 1);
        end
        fork
            begin
                drive_aw(wa, wid, wlen, wsz, wbt);
                drive_w(wlen);
            end
            drive_ar(ra, rid, rlen, rsz, rbt);
        join
        drain();
    endtask

    // FIFO full flags: random back-pressure or a forced pattern.
    initial begin : flag_drv
        forever begin
            @(posedge hclk); #1;
            if (rand_full_en) begin
                addr_fifo_full    = ($urandom_range(0, 5) == 0);
                data_fifo_full    = ($urandom_range(0, 5) == 0);
                state_fifo_full   = ($urandom_range(0, 7) == 0);
                id_send_fifo_full = ($urandom_range(0, 7) == 0);
                size_fifo_full    = ($urandom_range(0, 7) == 0);
            end else begin
                {addr_fifo_full, data_fifo_full, state_fifo_full, id_send_fifo_full, size_fifo_full} = forced_full;
            end
        end
    end

    // Monitor: every grant and every push is matched against the scoreboard.
    initial begin : monitor
        beat_t  e;
        grant_t g;
        logic   any_push;
        forever begin
            @(negedge hclk);
            any_push = addr_w_en | data_w_en | state_w_en | id_send_w_en | size_w_en;
            if ((awvalid && awready) || (arvalid && arready)) begin
                if (grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: actual aw=%0b ar=%0b required=no grant", awready, arready);
                end else begin
                    g = grant_q.pop_front();
                    chk("grant_side", 64'(awready), 64'(g.wr));
                    chk("grant_exclusive", 64'(awready & arready), 64'd0);
                    chk("capture_burst_err", 64'(burst_err), 64'(g.cap_err));
                end
            end else if (any_push) begin
                chk("push_group", 64'({addr_w_en, state_w_en, id_send_w_en, size_w_en}), 64'hF);
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_push: actual addr=%0h required=no push", cmd_addr);
                end else begin
                    e = beat_q.pop_front();
                    chk("cmd_addr", 64'(cmd_addr), 64'(e.addr));
                    chk("cmd_write", 64'(cmd_write), 64'(e.wr));
                    chk("data_w_en", 64'(data_w_en), 64'(e.wr));
                    chk("cmd_id", 64'(cmd_id), 64'(e.id));
                    chk("cmd_size", 64'(cmd_size), 64'(e.size));
                    chk("beat_burst_err", 64'(burst_err), 64'(e.err));
                    if (e.wr) chk("cmd_data", cmd_data, e.data);
                end
            end else begin
                chk("quiet_burst_err", 64'(burst_err), 64'd0);
            end
        end
    end

    initial begin : stimulus
        logic [31:0]     ra, wa;
        logic [ID_W-1:0] rid, wid;
        int unsigned     rlen, wlen, rsz, wsz, rbt, wbt;

        repeat (3) @(posedge hclk);
        @(negedge hclk);
        chk("rst_ready", 64'({awready, wready, arready}), 64'd0);
        chk("rst_w_en", 64'({addr_w_en, data_w_en, state_w_en, id_send_w_en, size_w_en}), 64'd0);
        chk("rst_burst_err", 64'(burst_err), 64'd0);
        chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        chk("rst_cmd_data", cmd_data, 64'd0);
        chk("rst_cmd_misc", 64'({cmd_write, cmd_id, cmd_size}), 64'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;

        // Both valid straight out of reset: write (with A0..A3 data) then read.
        data_fixed = 1'b1;
        data_base  = 64'hA0;
        run_both(32'h1000, 9'h011, 3, 3, 1, 32'h5000, 9'h022, 1, 3, 1);
        data_fixed = 1'b0;

        // Read stalled by a full id_send FIFO.
        forced_full = 5'b00010;
        repeat (2) @(posedge hclk); #1;
        model_burst(1'b0, 32'h2004, 9'h033, 1, 2, 1, 2);
        drive_ar(32'h2004, 9'h033, 1, 2, 1);
        repeat (3) begin
            @(negedge hclk);
            chk("stall_no_push", 64'({addr_w_en, data_w_en, state_w_en, id_send_w_en, size_w_en}), 64'd0);
        end
        forced_full = '0;
        prio_w_m = 1'b1;
        drain();

        // WRAP read.
        run_read(32'h3038, 9'h044, 3, 3, 2);

        // wlast asserted early on beat 0 of a 2-beat write.
        wl_mode = 2;
        run_write(32'h6000, 9'h055, 1, 3, 1);
        wl_mode = 0;

        // Read holds priority now: read first, then write.
        run_both(32'h7000, 9'h066, 2, 2, 1, 32'h8000, 9'h077, 2, 2, 1);

        // Reset after beat 1 of a 4-beat read.
        model_burst(1'b0, 32'h4000, 9'h088, 3, 3, 1, 2);
        drive_ar(32'h4000, 9'h088, 3, 3, 1);
        @(posedge hclk);
        @(posedge hclk); #1;
        hreset = 1'b1;
        repeat (2) begin
            @(negedge hclk);
            chk("reset_no_push", 64'({addr_w_en, data_w_en, state_w_en, id_send_w_en, size_w_en}), 64'd0);
        end
        @(posedge hclk); #1;
        hreset = 1'b0;
        prio_w_m = 1'b1;
        drain();

`ifdef BURST_4K_CHECK_EN
        run_write(32'h0000_0FF8, 9'h099, 1, 3, 1);
`endif

        // Randomized bursts with back-pressure, W gaps and occasional bad wlast.
        rand_full_en = 1'b1;
        gap_en       = 1'b1;
        wl_mode      = 1;
        for (int unsigned k = 0; k < 40; k++) begin
            wa = $urandom; wid = ID_W'($urandom); wlen = $urandom_range(0, 15);
            wsz = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            wbt = $urandom_range(0, 3);
            ra = $urandom; rid = ID_W'($urandom); rlen = $urandom_range(0, 15);
            rsz = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            rbt = $urandom_range(0, 3);
            if (k % 5 == 4)               run_both(wa, wid, wlen, wsz, wbt, ra, rid, rlen, rsz, rbt);
            else if ($urandom_range(0, 1)) run_write(wa, wid, wlen, wsz, wbt);
            else                           run_read(ra, rid, rlen, rsz, rbt);
        end
        rand_full_en = 1'b0;
        repeat (3) @(posedge hclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
